// File: rtl/fft_coef_loader_pkg.sv
// Shared definitions for the FFT coefficient loader: FSM encoding, fill modes
// and the values written to out-of-band bins.
package fft_coef_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_FRAME = 2'd1,
        ST_LOAD       = 2'd2,
        ST_DONE       = 2'd3
    } state_e;

    localparam logic [15:0] COS_UNITY = 16'h7FFF;
    localparam logic [15:0] SIN_ZERO  = 16'h0000;
    localparam logic [31:0] ZOOM_ZERO = 32'h0000_0000;

    localparam logic FILL_STREAM = 1'b0;
    localparam logic FILL_BAND   = 1'b1;

endpackage

// File: rtl/fft_coef_loader_band_gen.sv
// Combinational band-table generator: captured gain/rotation inside [lo,hi],
// zero gain and identity rotation elsewhere.
module fft_coef_band_gen
    import fft_coef_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 14
) (
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [ADDR_WIDTH-1:0] i_lo,
    input  logic [ADDR_WIDTH-1:0] i_hi,
    input  logic [31:0]           i_zoom,
    input  logic [15:0]           i_sin,
    input  logic [15:0]           i_cos,
    output logic [31:0]           o_zoom,
    output logic [15:0]           o_sin,
    output logic [15:0]           o_cos
);

    logic in_band;

    // lo > hi makes this false for every address, giving an all-stop table.
    assign in_band = (i_addr >= i_lo) && (i_addr <= i_hi);

    always_comb begin
        o_zoom = ZOOM_ZERO;
        o_sin  = SIN_ZERO;
        o_cos  = COS_UNITY;
        if (in_band) begin
            o_zoom = i_zoom;
            o_sin  = i_sin;
            o_cos  = i_cos;
        end
    end

endmodule

// File: rtl/fft_coef_loader.sv
// Write-side driver of the FFT sin/cos/zoom coefficient RAMs. Loads a streamed
// or generated table, starting only after a frame end so frames never see a mix.
module fft_coef_loader
    import fft_coef_loader_pkg::*;
#(
    parameter int FFT_POINT  = 8192,
    parameter int ADDR_WIDTH = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic                  i_fill_mode,
    input  logic [ADDR_WIDTH-1:0] i_band_lo,
    input  logic [ADDR_WIDTH-1:0] i_band_hi,
    input  logic [31:0]           i_band_zoom,
    input  logic [15:0]           i_band_sin,
    input  logic [15:0]           i_band_cos,
    input  logic [15:0]           i_s_sin,
    input  logic [15:0]           i_s_cos,
    input  logic [31:0]           i_s_zoom,
    input  logic                  i_s_valid,
    input  logic                  i_s_last,
    output logic                  o_s_ready,
    input  logic                  i_frame_last,
    input  logic                  i_frame_valid,
    output logic [31:0]           o_FFT_wr_addr,
    output logic [31:0]           o_FFT_phase_sin,
    output logic [31:0]           o_FFT_phase_cos,
    output logic [31:0]           o_FFT_zoom_data,
    output logic                  o_FFT_ram_wea,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FFT_POINT - 1);

    // Stream handshake: a beat transfers on a cycle where i_s_valid and
    // o_s_ready are both high at the rising edge; valid may drop freely.
    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  mode_q, mode_d;
    logic [ADDR_WIDTH-1:0] lo_q, lo_d, hi_q, hi_d;
    logic [31:0]           gzoom_q, gzoom_d;
    logic [15:0]           gsin_q, gsin_d, gcos_q, gcos_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           zoom_q, zoom_d;
    logic [15:0]           sin_q, sin_d, cos_q, cos_d;
    logic                  wea_q, wea_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic [31:0] band_zoom;
    logic [15:0] band_sin, band_cos;

    fft_coef_band_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_band_gen (
        .i_addr (cnt_q),
        .i_lo   (lo_q),
        .i_hi   (hi_q),
        .i_zoom (gzoom_q),
        .i_sin  (gsin_q),
        .i_cos  (gcos_q),
        .o_zoom (band_zoom),
        .o_sin  (band_sin),
        .o_cos  (band_cos)
    );

    assign o_s_ready = (state_q == ST_LOAD) && (mode_q == FILL_STREAM);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        gzoom_d = gzoom_q;
        gsin_d  = gsin_q;
        gcos_d  = gcos_q;
        addr_d  = addr_q;
        zoom_d  = zoom_q;
        sin_d   = sin_q;
        cos_d   = cos_q;
        wea_d   = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    mode_d  = i_fill_mode;
                    lo_d    = i_band_lo;
                    hi_d    = i_band_hi;
                    gzoom_d = i_band_zoom;
                    gsin_d  = i_band_sin;
                    gcos_d  = i_band_cos;
                    err_d   = 1'b0;
                    busy_d  = 1'b1;
                    state_d = ST_WAIT_FRAME;
                end
            end
            ST_WAIT_FRAME: begin
                if (i_frame_valid && i_frame_last) begin
                    cnt_d   = '0;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (mode_q == FILL_BAND) begin
                    wea_d  = 1'b1;
                    addr_d = cnt_q;
                    zoom_d = band_zoom;
                    sin_d  = band_sin;
                    cos_d  = band_cos;
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == LAST_ADDR) begin
                        state_d = ST_DONE;
                    end
                end else if (i_s_valid) begin
                    wea_d  = 1'b1;
                    addr_d = cnt_q;
                    zoom_d = i_s_zoom;
                    sin_d  = i_s_sin;
                    cos_d  = i_s_cos;
                    cnt_d  = cnt_q + 1'b1;
                    // Table length must match FFT_POINT exactly; either mismatch flags err.
                    if (cnt_q == LAST_ADDR) begin
                        state_d = ST_DONE;
                        if (!i_s_last) begin
                            err_d = 1'b1;
                        end
                    end else if (i_s_last) begin
                        state_d = ST_DONE;
                        err_d   = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            lo_q    <= '0;
            hi_q    <= '0;
            gzoom_q <= '0;
            gsin_q  <= '0;
            gcos_q  <= '0;
            addr_q  <= '0;
            zoom_q  <= '0;
            sin_q   <= '0;
            cos_q   <= '0;
            wea_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            gzoom_q <= gzoom_d;
            gsin_q  <= gsin_d;
            gcos_q  <= gcos_d;
            addr_q  <= addr_d;
            zoom_q  <= zoom_d;
            sin_q   <= sin_d;
            cos_q   <= cos_d;
            wea_q   <= wea_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign o_FFT_wr_addr   = 32'(addr_q);
    assign o_FFT_phase_sin = {16'b0, sin_q};
    assign o_FFT_phase_cos = {16'b0, cos_q};
    assign o_FFT_zoom_data = zoom_q;
    assign o_FFT_ram_wea   = wea_q;
    assign o_busy          = busy_q;
    assign o_done          = done_q;
    assign o_err           = err_q;

endmodule

// File: tb/tb_fft_coef_loader.sv
// Bench for fft_coef_loader with a 16-entry table: band fills, streamed loads,
// length errors, frame alignment and mid-load reset.
module tb_fft_coef_loader;
    import fft_coef_loader_pkg::*;

    localparam int FFT_POINT  = 16;
    localparam int ADDR_WIDTH = 14;
    localparam int W          = 128;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic                  i_start = 1'b0, i_fill_mode = 1'b0;
    logic [ADDR_WIDTH-1:0] i_band_lo = '0, i_band_hi = '0;
    logic [31:0]           i_band_zoom = '0;
    logic [15:0]           i_band_sin = '0, i_band_cos = '0;
    logic [15:0]           i_s_sin = '0, i_s_cos = '0;
    logic [31:0]           i_s_zoom = '0;
    logic                  i_s_valid = 1'b0, i_s_last = 1'b0;
    logic                  o_s_ready;
    logic                  i_frame_last = 1'b0, i_frame_valid = 1'b0;
    logic [31:0]           o_FFT_wr_addr, o_FFT_phase_sin, o_FFT_phase_cos, o_FFT_zoom_data;
    logic                  o_FFT_ram_wea, o_busy, o_done, o_err;

    fft_coef_loader #(.FFT_POINT(FFT_POINT), .ADDR_WIDTH(ADDR_WIDTH)) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_fill_mode(i_fill_mode),
        .i_band_lo(i_band_lo), .i_band_hi(i_band_hi), .i_band_zoom(i_band_zoom),
        .i_band_sin(i_band_sin), .i_band_cos(i_band_cos),
        .i_s_sin(i_s_sin), .i_s_cos(i_s_cos), .i_s_zoom(i_s_zoom),
        .i_s_valid(i_s_valid), .i_s_last(i_s_last), .o_s_ready(o_s_ready),
        .i_frame_last(i_frame_last), .i_frame_valid(i_frame_valid),
        .o_FFT_wr_addr(o_FFT_wr_addr), .o_FFT_phase_sin(o_FFT_phase_sin),
        .o_FFT_phase_cos(o_FFT_phase_cos), .o_FFT_zoom_data(o_FFT_zoom_data),
        .o_FFT_ram_wea(o_FFT_ram_wea), .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] mon_w, mon_e;
    int wea_cnt = 0, done_cnt = 0;
    int first_wea_cyc = -1, last_wea_cyc = 0, done_cyc = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst && o_FFT_ram_wea) begin
            mon_w = {o_FFT_wr_addr, o_FFT_zoom_data, o_FFT_phase_sin, o_FFT_phase_cos};
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got %0h expected no write", mon_w);
            end else begin
                mon_e = exp_q.pop_front();
                check("ram_write", mon_w, mon_e);
            end
            if (first_wea_cyc < 0) first_wea_cyc = cyc;
            last_wea_cyc = cyc;
            wea_cnt++;
        end
        if (o_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    function automatic logic [W-1:0] pack_w(input int addr, input logic [31:0] zoom,
                                             input logic [15:0] s, input logic [15:0] c);
        return {32'(addr), zoom, 16'h0, s, 16'h0, c};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic start_load(input logic mode, input int lo, input int hi,
                              input logic [31:0] zoom, input logic [15:0] s, input logic [15:0] c);
        i_start     = 1'b1;
        i_fill_mode = mode;
        i_band_lo   = ADDR_WIDTH'(lo);
        i_band_hi   = ADDR_WIDTH'(hi);
        i_band_zoom = zoom;
        i_band_sin  = s;
        i_band_cos  = c;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic frame_end();
        i_frame_valid = 1'b1;
        i_frame_last  = 1'b1;
        @(negedge clk);
        i_frame_valid = 1'b0;
        i_frame_last  = 1'b0;
    endtask

    task automatic send_beat(input int gap, input logic [15:0] s, input logic [15:0] c,
                             input logic [31:0] zoom, input logic last);
        logic r;
        bit   ok;
        repeat (gap) @(negedge clk);
        i_s_valid = 1'b1;
        i_s_sin   = s;
        i_s_cos   = c;
        i_s_zoom  = zoom;
        i_s_last  = last;
        ok = 1'b0;
        for (int t = 0; t < 300; t++) begin
            r = o_s_ready;
            @(negedge clk);
            if (r) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL beat_accept: got timeout expected ready");
        end
        i_s_valid = 1'b0;
        i_s_last  = 1'b0;
    endtask

    task automatic wait_done(input string name, input int base);
        for (int t = 0; t < 300; t++) begin
            @(posedge clk);
            if (done_cnt > base) break;
        end
        @(negedge clk);
        repeat (3) @(negedge clk);
        check({name, "_done_count"}, W'(done_cnt - base), W'(1));
    endtask

    // ---------------- test ----------------
    typedef struct {
        int          addr;
        logic [31:0] zoom;
        logic [15:0] s;
        logic [15:0] c;
    } vec_t;

    vec_t band_tbl[FFT_POINT];
    int   base_done, base_wea;

    initial begin
        // Band table for lo=10, hi=12 (hand-specified values)
        for (int i = 0; i < FFT_POINT; i++) begin
            band_tbl[i].addr = i;
            if (i >= 10 && i <= 12) begin
                band_tbl[i].zoom = 32'h0002_0000;
                band_tbl[i].s    = 16'h4000;
                band_tbl[i].c    = 16'h6000;
            end else begin
                band_tbl[i].zoom = 32'h0;
                band_tbl[i].s    = 16'h0;
                band_tbl[i].c    = 16'h7FFF;
            end
        end

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_wea",   W'(o_FFT_ram_wea), W'(0));
        check("reset_busy",  W'(o_busy), W'(0));
        check("reset_done",  W'(o_done), W'(0));
        check("reset_err",   W'(o_err), W'(0));
        check("reset_ready", W'(o_s_ready), W'(0));
        check("reset_addr",  W'(o_FFT_wr_addr), W'(0));
        check("reset_state", W'(dut.state_q), W'(ST_IDLE));
        rst = 1'b1;
        @(negedge clk);

        // Band fill lo=10..hi=12
        for (int i = 0; i < FFT_POINT; i++)
            exp_q.push_back(pack_w(band_tbl[i].addr, band_tbl[i].zoom, band_tbl[i].s, band_tbl[i].c));
        base_done = done_cnt;
        base_wea  = wea_cnt;
        first_wea_cyc = -1;
        start_load(FILL_BAND, 10, 12, 32'h0002_0000, 16'h4000, 16'h6000);
        repeat (4) @(negedge clk);
        check("band_busy_wait", W'(o_busy), W'(1));
        check("band_ready_low", W'(o_s_ready), W'(0));
        frame_end();
        wait_done("band", base_done);
        check("band_writes", W'(wea_cnt - base_wea), W'(FFT_POINT));
        check("band_consecutive", W'(last_wea_cyc - first_wea_cyc), W'(FFT_POINT - 1));
        check("band_done_timing", W'(done_cyc - last_wea_cyc), W'(1));
        check("band_busy_after", W'(o_busy), W'(0));
        check("band_err", W'(o_err), W'(0));

        // i_start coincident with frame end; lo > hi gives an all-stop table
        base_done = done_cnt;
        base_wea  = wea_cnt;
        i_frame_valid = 1'b1;
        i_frame_last  = 1'b1;
        start_load(FILL_BAND, 3, 1, 32'h0001_0000, 16'h1234, 16'h5678);
        i_frame_valid = 1'b0;
        i_frame_last  = 1'b0;
        repeat (3) @(negedge clk);
        start_load(FILL_STREAM, 0, 15, 32'hFFFF_FFFF, 16'h1111, 16'h2222);
        repeat (3) @(negedge clk);
        check("coinc_no_write", W'(wea_cnt - base_wea), W'(0));
        check("coinc_busy", W'(o_busy), W'(1));
        check("coinc_state", W'(dut.state_q), W'(ST_WAIT_FRAME));
        for (int i = 0; i < FFT_POINT; i++)
            exp_q.push_back(pack_w(i, 32'h0, 16'h0, 16'h7FFF));
        frame_end();
        wait_done("coinc", base_done);
        check("coinc_writes", W'(wea_cnt - base_wea), W'(FFT_POINT));

        // Stream: 16 beats, random gaps, last on beat 16
        base_done = done_cnt;
        base_wea  = wea_cnt;
        start_load(FILL_STREAM, 0, 0, 32'h0, 16'h0, 16'h0);
        frame_end();
        for (int b = 0; b < FFT_POINT; b++) begin
            exp_q.push_back(pack_w(b, 32'h0001_0000 + b, 16'h1000 + 16'(b), 16'h2000 + 16'(b)));
            send_beat($urandom_range(0, 3), 16'h1000 + 16'(b), 16'h2000 + 16'(b),
                      32'h0001_0000 + b, b == FFT_POINT - 1);
        end
        wait_done("stream16", base_done);
        check("stream16_writes", W'(wea_cnt - base_wea), W'(FFT_POINT));
        check("stream16_err", W'(o_err), W'(0));
        check("stream16_ready", W'(o_s_ready), W'(0));
        check("stream16_queue", W'(exp_q.size()), W'(0));

        // Stream: early last on beat 5
        base_done = done_cnt;
        base_wea  = wea_cnt;
        start_load(FILL_STREAM, 0, 0, 32'h0, 16'h0, 16'h0);
        frame_end();
        for (int b = 0; b < 5; b++) begin
            exp_q.push_back(pack_w(b, 32'hA000_0000 + b, 16'h0A00 + 16'(b), 16'h0B00 + 16'(b)));
            send_beat(b % 2, 16'h0A00 + 16'(b), 16'h0B00 + 16'(b), 32'hA000_0000 + b, b == 4);
        end
        wait_done("early", base_done);
        check("early_writes", W'(wea_cnt - base_wea), W'(5));
        check("early_err", W'(o_err), W'(1));
        check("early_ready", W'(o_s_ready), W'(0));

        // Stream: 16 beats without last
        base_done = done_cnt;
        base_wea  = wea_cnt;
        start_load(FILL_STREAM, 0, 0, 32'h0, 16'h0, 16'h0);
        frame_end();
        for (int b = 0; b < FFT_POINT; b++) begin
            exp_q.push_back(pack_w(b, 32'h5000_0000 + b, 16'h0C00 + 16'(b), 16'h0D00 + 16'(b)));
            send_beat($urandom_range(0, 2), 16'h0C00 + 16'(b), 16'h0D00 + 16'(b),
                      32'h5000_0000 + b, 1'b0);
        end
        wait_done("nolast", base_done);
        check("nolast_writes", W'(wea_cnt - base_wea), W'(FFT_POINT));
        check("nolast_err", W'(o_err), W'(1));
        start_load(FILL_BAND, 0, 15, 32'h0000_8000, 16'h0100, 16'h0200);
        check("restart_err_clear", W'(o_err), W'(0));
        check("restart_busy", W'(o_busy), W'(1));

        // Reset in the middle of a band load
        for (int i = 0; i < FFT_POINT; i++)
            exp_q.push_back(pack_w(i, 32'h0000_8000, 16'h0100, 16'h0200));
        base_done = done_cnt;
        base_wea  = wea_cnt;
        frame_end();
        for (int t = 0; t < 100; t++) begin
            if (wea_cnt - base_wea >= 8) break;
            @(negedge clk);
        end
        rst = 1'b0;
        @(negedge clk);
        check("midrst_wea",   W'(o_FFT_ram_wea), W'(0));
        check("midrst_busy",  W'(o_busy), W'(0));
        check("midrst_state", W'(dut.state_q), W'(ST_IDLE));
        rst = 1'b1;
        exp_q.delete();
        repeat (2) @(negedge clk);
        check("midrst_no_done", W'(done_cnt - base_done), W'(0));

        // Normal load after reset, all bins in band
        for (int i = 0; i < FFT_POINT; i++)
            exp_q.push_back(pack_w(i, 32'h0003_0000, 16'hC000, 16'h8001));
        base_done = done_cnt;
        base_wea  = wea_cnt;
        start_load(FILL_BAND, 0, 15, 32'h0003_0000, 16'hC000, 16'h8001);
        frame_end();
        wait_done("postrst", base_done);
        check("postrst_writes", W'(wea_cnt - base_wea), W'(FFT_POINT));
        check("postrst_err", W'(o_err), W'(0));
        check("final_queue", W'(exp_q.size()), W'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fft_coef_loader.md
Name: fft_coef_loader

Overview:
- Write-side companion of the FFT filter's coefficient RAMs.
- Drives the shared write port (sin, cos, zoom RAMs) that the rotate/zoom path reads: address, write enable and the three data words.
- Two sources: a streamed table from the PS, or an internally generated band-pass table (gain/phase inside [lo,hi], unity-free zero outside).
- Starts writing only at a frame boundary, so a spectrum frame never sees a half-updated table; signals busy/done/error to software.

Parameters:
- FFT_POINT, 8192, bins per frame = RAM entries written per load
- ADDR_WIDTH, 14, coefficient RAM address width (FFT_POINT <= 2**ADDR_WIDTH)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset
- i_start  in  1  one-cycle load request; ignored unless IDLE
- i_fill_mode  in  1  0 = streamed table, 1 = generated band table; sampled with i_start
- i_band_lo  in  ADDR_WIDTH  first bin of band (mode 1), sampled with i_start
- i_band_hi  in  ADDR_WIDTH  last bin of band (mode 1), sampled with i_start
- i_band_zoom  in  32  in-band gain, Q16.16 unsigned (bits 15:0 fraction)
- i_band_sin  in  16  in-band rotation sine, signed Q1.15
- i_band_cos  in  16  in-band rotation cosine, signed Q1.15
- i_s_sin  in  16  streamed sine
- i_s_cos  in  16  streamed cosine
- i_s_zoom  in  32  streamed gain
- i_s_valid  in  1  stream beat valid
- i_s_last  in  1  stream end marker
- o_s_ready  out  1  stream ready
- i_frame_last  in  1  FFT data-stream last, qualified by i_frame_valid
- i_frame_valid  in  1  FFT data-stream valid
- o_FFT_wr_addr  out  32  write address, zero-extended from ADDR_WIDTH
- o_FFT_phase_sin  out  32  {16'b0, sin}
- o_FFT_phase_cos  out  32  {16'b0, cos}
- o_FFT_zoom_data  out  32  gain word
- o_FFT_ram_wea  out  1  RAM write enable; high also steers RAM address mux to write side
- o_busy  out  1  high from accepted i_start until DONE
- o_done  out  1  one-cycle pulse at end of load
- o_err  out  1  sticky stream-length error; cleared by next accepted i_start

Behaviour:
- Reset (rst=0 at posedge): state IDLE; all outputs 0; counter 0; captured settings 0.
- States:
  - IDLE: on i_start, capture mode/band/gain/sin/cos, clear o_err, set o_busy, go WAIT_FRAME.
  - WAIT_FRAME: wait for i_frame_valid & i_frame_last, then go LOAD with addr=0 on the next cycle.
  - LOAD: write entries; at the final write go DONE.
  - DONE: o_done=1 for one cycle, o_busy=0, back to IDLE.
- Frame boundary: if i_frame_valid & i_frame_last occurs on the same cycle as i_start, it does NOT count. The loader waits for the next frame end.
- Mode 1, band fill:
  - One write per cycle, addr 0..FFT_POINT-1, so LOAD lasts exactly FFT_POINT cycles.
  - lo <= addr <= hi: zoom/sin/cos = captured values.
  - Otherwise: zoom=0, sin=0, cos=16'h7FFF.
  - lo > hi: every bin is out-of-band; no error.
  - Bins >= FFT_POINT are never addressed.
- Mode 0, stream:
  - o_s_ready=1 only in LOAD.
  - Each i_s_valid & o_s_ready beat writes at the current addr, then addr increments.
  - Stalls (valid=0) leave o_FFT_ram_wea=0 and addr unchanged.
  - Beat at addr FFT_POINT-1 ends the load whether or not i_s_last is set. i_s_last=0 on it sets o_err.
  - i_s_last on an earlier beat: that beat is written, o_err set, load ends (DONE). Remaining entries keep old contents.
- Output timing: write outputs are registered, so wea/addr/data appear one cycle after the beat/count that produced them. o_done is asserted the cycle after the final wea pulse.
- Write side and read side are exclusive: o_FFT_ram_wea is never high outside LOAD (+1 cycle pipeline).
- i_start while not IDLE: ignored, no effect on captured values.
- Reset mid-LOAD: immediate return to IDLE; partial table remains, no o_done.

Decomposition:
- Shared package holds:
  - state encoding (IDLE/WAIT_FRAME/LOAD/DONE)
  - COS_UNITY=16'h7FFF, SIN_ZERO=0, ZOOM_ZERO=0
  - FILL_STREAM=0, FILL_BAND=1
- One natural sub-module: fft_coef_band_gen (combinational in-band compare plus value mux from addr and captured settings).
- FSM, counter and output registers stay in the top.

Test Plan:
- Reset during LOAD at addr 100 -> next cycle wea=0, busy=0, state IDLE; later i_start works normally, o_err=0.
- Mode 1, lo=10, hi=12, zoom=0x00020000, sin=0x4000, cos=0x6000, FFT_POINT=16:
  - i_start, then frame last -> 16 consecutive wea cycles, addr 0..15.
  - Addr 10-12 carry the band values; others zoom=0, sin=0, cos=0x7FFF.
  - o_done one cycle after addr 15.
- i_start coincident with frame last -> no write until the following frame last; busy high throughout the wait.
- Mode 0, FFT_POINT=16, 16 beats with random valid gaps, last on beat 16 -> exactly 16 writes, addresses 0..15 in order, o_err=0, one o_done.
- Mode 0, i_s_last on beat 5 -> 5 writes (addr 0..4), o_err=1, o_done pulses, ready drops.
- Mode 0, 16 beats with no last -> load ends at addr 15, o_err=1; next i_start clears o_err.
